// File: rtl/jtkunio_mmio.sv
// CPU-facing IO registers: scroll, sound latch, flip, ROM bank and edge-triggered IRQs.
// Define JTKUNIO_MMIO_SCRBUF_EN to hold scroll writes until the start of vertical blank.
module jtkunio_mmio #(
  parameter int BANKW = 1,
  parameter int SCRW  = 10,
  parameter int NIRQ  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             io_cs,
  input  logic             rnw,
  input  logic [3:0]       addr,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  input  logic             LVBL,
  input  logic [NIRQ-1:0]  irq_src,
  output logic             irq_n,
  input  logic             snd_ack,
  output logic [7:0]       snd_latch,
  output logic             snd_irq,
  output logic [SCRW-1:0]  scrpos,
  output logic             flip,
  output logic [BANKW-1:0] bank
);

  logic [1:0]      rst_sync;
  logic            rst_ok;
  logic            wr;
  logic [15:0]     wsel;
  logic [SCRW-1:0] stage;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] src_last;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] clr;

  // Writes and IRQ posting stay blocked until the released reset has crossed two flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ok = rst_sync[1];
  assign wr     = io_cs & ~rnw & cen & rst_ok;
  assign wsel   = wr ? (16'd1 << addr) : 16'd0;
  assign rise   = rst_ok ? (irq_src & ~src_last) : '0;
  assign clr    = wsel[6] ? din[NIRQ-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      flip      <= 1'b0;
      bank      <= '0;
      mask      <= '0;
      snd_latch <= 8'h00;
      snd_irq   <= 1'b0;
    end else begin
      if (wsel[0]) stage[7:0]      <= din;
      if (wsel[1]) stage[SCRW-1:8] <= din[SCRW-9:0];
      if (wsel[3]) flip            <= din[0];
      if (wsel[4]) bank            <= din[BANKW-1:0];
      if (wsel[5]) mask            <= din[NIRQ-1:0];
      if (wsel[2]) begin
        snd_latch <= din;
        snd_irq   <= 1'b1;
      end else if (snd_ack) begin
        snd_irq   <= 1'b0;
      end
    end
  end

  // A new edge outranks a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_last <= '0;
      pending  <= '0;
      irq_n    <= 1'b1;
    end else begin
      src_last <= irq_src;
      pending  <= (pending & ~clr) | rise;
      irq_n    <= ~|(pending & mask);
    end
  end

`ifdef JTKUNIO_MMIO_SCRBUF_EN
  logic lvbl_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_last <= 1'b0;
      scrpos    <= '0;
    end else begin
      lvbl_last <= LVBL;
      if (lvbl_last && !LVBL) scrpos <= stage;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scrpos <= '0;
    else        scrpos <= stage;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= 8'hFF;
    end else begin
      case (addr)
        4'h2:    dout <= {snd_irq, ~LVBL, 6'b0};
        4'h5:    dout <= 8'(mask);
        4'h7:    dout <= 8'(pending);
        default: dout <= 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkunio_mmio.sv
// Self-checking bench for jtkunio_mmio (BANKW=3, SCRW=10, NIRQ=8) against a cycle-level
// behavioural model; scroll expectations follow JTKUNIO_MMIO_SCRBUF_EN when defined.
module tb_jtkunio_mmio;
  localparam int BANKW = 3;
  localparam int SCRW  = 10;
  localparam int NIRQ  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b0, io_cs = 1'b0, rnw = 1'b1;
  logic [3:0]       addr = 4'h0;
  logic [7:0]       din = 8'h00;
  logic [7:0]       dout;
  logic             LVBL = 1'b1;
  logic [NIRQ-1:0]  irq_src = '0;
  logic             irq_n;
  logic             snd_ack = 1'b0;
  logic [7:0]       snd_latch;
  logic             snd_irq;
  logic [SCRW-1:0]  scrpos;
  logic             flip;
  logic [BANKW-1:0] bank;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [SCRW-1:0]  m_stage, m_scr;
  logic             m_flip, m_sndirq, m_irqn, m_lvbl_prev;
  logic [BANKW-1:0] m_bank;
  logic [7:0]       m_latch, m_dout;
  logic [NIRQ-1:0]  m_mask, m_pend, m_src_prev;
  int               m_rcnt;

  jtkunio_mmio #(.BANKW(BANKW), .SCRW(SCRW), .NIRQ(NIRQ)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .io_cs(io_cs), .rnw(rnw), .addr(addr),
    .din(din), .dout(dout), .LVBL(LVBL), .irq_src(irq_src), .irq_n(irq_n),
    .snd_ack(snd_ack), .snd_latch(snd_latch), .snd_irq(snd_irq), .scrpos(scrpos),
    .flip(flip), .bank(bank)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_stage = '0; m_scr = '0; m_flip = 0; m_bank = '0; m_latch = 8'h00; m_sndirq = 0;
    m_mask = '0; m_pend = '0; m_src_prev = '0; m_lvbl_prev = 0; m_dout = 8'hFF;
    m_irqn = 1; m_rcnt = 0;
  endtask

  // One clock: the model applies the register rules to the inputs seen at the rising edge
  task automatic tick();
    logic            w;
    logic [NIRQ-1:0] rise, clr;
    @(posedge clk);
    if (rst_n) begin
      w    = io_cs && !rnw && cen && (m_rcnt >= 2);
      rise = (m_rcnt >= 2) ? (irq_src & ~m_src_prev) : '0;
      clr  = (w && addr == 4'h6) ? din : '0;
      case (addr)
        4'h2:    m_dout = {m_sndirq, ~LVBL, 6'b0};
        4'h5:    m_dout = m_mask;
        4'h7:    m_dout = m_pend;
        default: m_dout = 8'hFF;
      endcase
      m_irqn = ((m_pend & m_mask) == 0);
`ifdef JTKUNIO_MMIO_SCRBUF_EN
      if (m_lvbl_prev && !LVBL) m_scr = m_stage;
`else
      m_scr = m_stage;
`endif
      m_lvbl_prev = LVBL;
      m_src_prev  = irq_src;
      m_pend      = (m_pend & ~clr) | rise;
      if (w) begin
        case (addr)
          4'h0: m_stage[7:0] = din;
          4'h1: m_stage[SCRW-1:8] = din[SCRW-9:0];
          4'h2: m_latch = din;
          4'h3: m_flip = din[0];
          4'h4: m_bank = din[BANKW-1:0];
          4'h5: m_mask = din;
          default: ;
        endcase
      end
      if (w && addr == 4'h2) m_sndirq = 1;
      else if (snd_ack)      m_sndirq = 0;
      if (m_rcnt < 2) m_rcnt++;
    end
    @(negedge clk);
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    io_cs = 1; rnw = 0; cen = 1; addr = a; din = d;
    tick();
    io_cs = 0; rnw = 1; cen = 0;
  endtask

  task automatic do_reset(input logic [NIRQ-1:0] hold_src);
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      {cen, io_cs, rnw, snd_ack, LVBL} = 5'($urandom);
      addr = 4'($urandom); din = 8'($urandom); irq_src = NIRQ'($urandom);
      tick();
    end
    io_cs = 0; cen = 0; rnw = 1; snd_ack = 0; LVBL = 1; irq_src = hold_src; addr = 4'h0;
  endtask

  task automatic test_reset();
    do_reset('0);
    if (scrpos !== 10'h000) begin n_bad++; $display("FAIL reset_scrpos got %h want 000", scrpos); end
    n_vec++;
    if (bank !== 3'b000) begin n_bad++; $display("FAIL reset_bank got %b want 000", bank); end
    n_vec++;
    if (snd_irq !== 1'b0) begin n_bad++; $display("FAIL reset_snd_irq got %b want 0", snd_irq); end
    n_vec++;
    if (irq_n !== 1'b1) begin n_bad++; $display("FAIL reset_irq_n got %b want 1", irq_n); end
    n_vec++;
    if (dout !== 8'hFF) begin n_bad++; $display("FAIL reset_dout got %h want ff", dout); end
    n_vec++;
    rst_n = 1;
    write(4'h4, 8'hFF);
    write(4'h2, 8'h77);
    if (bank !== 3'b000 || snd_irq !== 1'b0) begin
      n_bad++; $display("FAIL reset_early_write got bank=%b snd_irq=%b want 000/0", bank, snd_irq);
    end
    n_vec++;
  endtask

  task automatic test_irq();
    write(4'h5, 8'h03);
    irq_src = 8'h02; tick();
    irq_src = 8'h00; tick();
    if (irq_n !== 1'b0) begin n_bad++; $display("FAIL irq_assert got %b want 0", irq_n); end
    n_vec++;
    addr = 4'h7; tick();
    if (dout !== 8'h02) begin n_bad++; $display("FAIL irq_pending got %h want 02", dout); end
    n_vec++;
    write(4'h6, 8'h02);
    tick();
    if (irq_n !== 1'b1) begin n_bad++; $display("FAIL irq_clear got %b want 1", irq_n); end
    n_vec++;
    irq_src = 8'h02;
    write(4'h6, 8'h02);
    addr = 4'h7; tick();
    if (dout !== 8'h02 || dout !== m_dout) begin
      n_bad++; $display("FAIL irq_set_wins got %h want 02", dout);
    end
    n_vec++;
    irq_src = 8'h00;
    write(4'h6, 8'hFF);
  endtask

  task automatic test_sound();
    write(4'h2, 8'h5A);
    if (snd_latch !== 8'h5A || snd_irq !== 1'b1) begin
      n_bad++; $display("FAIL snd_write got latch=%h irq=%b want 5a/1", snd_latch, snd_irq);
    end
    n_vec++;
    addr = 4'h2; tick();
    if (dout[7] !== 1'b1 || dout !== m_dout) begin
      n_bad++; $display("FAIL snd_status got %h want %h", dout, m_dout);
    end
    n_vec++;
    snd_ack = 1; tick(); snd_ack = 0;
    if (snd_irq !== 1'b0) begin n_bad++; $display("FAIL snd_ack got %b want 0", snd_irq); end
    n_vec++;
    snd_ack = 1;
    write(4'h2, 8'h3C);
    snd_ack = 0;
    if (snd_latch !== 8'h3C || snd_irq !== 1'b1) begin
      n_bad++; $display("FAIL snd_ack_write got latch=%h irq=%b want 3c/1", snd_latch, snd_irq);
    end
    n_vec++;
  endtask

  task automatic test_scroll();
    LVBL = 1; tick();
    write(4'h0, 8'h34);
    write(4'h1, 8'h02);
`ifdef JTKUNIO_MMIO_SCRBUF_EN
    tick();
    if (scrpos !== 10'h000) begin n_bad++; $display("FAIL scr_hold got %h want 000", scrpos); end
    n_vec++;
    LVBL = 0; tick();
    if (scrpos !== 10'h234) begin n_bad++; $display("FAIL scr_commit got %h want 234", scrpos); end
    n_vec++;
    LVBL = 1; tick();
    LVBL = 0;
    write(4'h0, 8'h55);
    if (scrpos !== 10'h234) begin n_bad++; $display("FAIL scr_same_clk got %h want 234", scrpos); end
    n_vec++;
    LVBL = 1; tick();
    LVBL = 0; tick();
    if (scrpos !== 10'h255) begin n_bad++; $display("FAIL scr_next_blank got %h want 255", scrpos); end
    n_vec++;
`else
    tick();
    if (scrpos !== 10'h234) begin n_bad++; $display("FAIL scr_follow got %h want 234", scrpos); end
    n_vec++;
    LVBL = 0; tick(); LVBL = 1; tick();
    if (scrpos !== 10'h234) begin n_bad++; $display("FAIL scr_lvbl_free got %h want 234", scrpos); end
    n_vec++;
`endif
  endtask

  task automatic test_params();
    logic [7:0] latch_before;
    write(4'h4, 8'hFF);
    if (bank !== 3'b111) begin n_bad++; $display("FAIL par_bank got %b want 111", bank); end
    n_vec++;
    write(4'h5, 8'hFF);
    irq_src = 8'hFF; tick();
    irq_src = 8'h00; addr = 4'h7; tick();
    if (dout !== 8'hFF) begin n_bad++; $display("FAIL par_pending got %h want ff", dout); end
    n_vec++;
    if (irq_n !== 1'b0) begin n_bad++; $display("FAIL par_irq_n got %b want 0", irq_n); end
    n_vec++;
    latch_before = snd_latch;
    for (int i = 0; i < 8; i++) begin
      io_cs = 1; rnw = 0; cen = 0; addr = 4'($urandom_range(0, 5)); din = 8'($urandom);
      tick();
    end
    io_cs = 0; rnw = 1;
    if (bank !== 3'b111 || snd_latch !== latch_before || scrpos !== m_scr || flip !== m_flip) begin
      n_bad++; $display("FAIL par_cen_low got bank=%b latch=%h scr=%h want 111/%h/%h",
                        bank, snd_latch, scrpos, latch_before, m_scr);
    end
    n_vec++;
    write(4'h6, 8'hFF);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      io_cs = ($urandom_range(0, 3) != 0); rnw = ($urandom_range(0, 3) == 0);
      cen = $urandom_range(0, 1); addr = 4'($urandom_range(0, 8)); din = 8'($urandom);
      LVBL = ($urandom_range(0, 7) != 0); snd_ack = ($urandom_range(0, 5) == 0);
      irq_src = NIRQ'($urandom);
      tick();
      if (dout !== m_dout) begin n_bad++; $display("FAIL rnd_dout cyc %0d got %h want %h", c, dout, m_dout); end
      n_vec++;
      if (irq_n !== m_irqn) begin n_bad++; $display("FAIL rnd_irq_n cyc %0d got %b want %b", c, irq_n, m_irqn); end
      n_vec++;
      if (scrpos !== m_scr) begin n_bad++; $display("FAIL rnd_scrpos cyc %0d got %h want %h", c, scrpos, m_scr); end
      n_vec++;
      if (snd_latch !== m_latch || snd_irq !== m_sndirq) begin
        n_bad++; $display("FAIL rnd_snd cyc %0d got %h/%b want %h/%b", c, snd_latch, snd_irq, m_latch, m_sndirq);
      end
      n_vec++;
      if (flip !== m_flip || bank !== m_bank) begin
        n_bad++; $display("FAIL rnd_flip_bank cyc %0d got %b/%b want %b/%b", c, flip, bank, m_flip, m_bank);
      end
      n_vec++;
    end
    io_cs = 0; cen = 0; rnw = 1; snd_ack = 0; LVBL = 1; irq_src = '0;
  endtask

  task automatic test_reset_mid();
    write(4'h5, 8'hFF);
    irq_src = 8'h01; tick();
    write(4'h2, 8'hAA);
    do_reset(8'h01);
    rst_n = 1;
    for (int i = 0; i < 4; i++) tick();
    write(4'h5, 8'hFF);
    addr = 4'h7; tick(); tick();
    if (dout !== 8'h00) begin n_bad++; $display("FAIL mid_pending got %h want 00", dout); end
    n_vec++;
    if (irq_n !== 1'b1 || snd_irq !== 1'b0) begin
      n_bad++; $display("FAIL mid_flags got irq_n=%b snd_irq=%b want 1/0", irq_n, snd_irq);
    end
    n_vec++;
    irq_src = 8'h00; tick();
    irq_src = 8'h01; tick(); tick();
    if (dout !== 8'h01) begin n_bad++; $display("FAIL mid_fresh_edge got %h want 01", dout); end
    n_vec++;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_irq();
    test_sound();
    test_scroll();
    test_params();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
